// File: rtl/display_pkg.sv
// Shared types and seven-segment glyph table for the display blocks.
// Glyphs are active-high in bit order {g,f,e,d,c,b,a}.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  // Per-frame copy of the inputs so the display never tears mid-frame.
  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        blank_lz;
  } snap_t;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
    logic [6:0] glyph;
    case (nibble)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_DASH;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/bcd_display_scanner_seg7_decoder.sv
// Combinational BCD nibble to active-high seven-segment glyph.
// Non-BCD codes render as a dash.
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = bcd_to_seg(nibble);

endmodule

// File: rtl/bcd_display_scanner.sv
// Four-digit multiplexed seven-segment scanner with blank gap between digits,
// per-frame input snapshot and optional leading-zero blanking.
module bcd_display_scanner
  import display_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [3:0] AN_POL  = {4{ACTIVE_LOW}};
  localparam logic [6:0] SEG_POL = {7{ACTIVE_LOW}};

  scan_state_t      state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  snap_t            snap_q, snap_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_done_q, frame_done_d;

  snap_t      inputs_snap;
  logic [3:0] lead_zero;
  logic [3:0] nibble;
  logic [6:0] glyph;
  logic       lit;

  assign inputs_snap = '{digits: digits, dp: dp_in, blank_lz: blank_lz};

  // Slot counter runs 0..REFRESH_DIV-1; SHOW covers the low part, BLANK the tail.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_W'(1);
    snap_d  = snap_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en) begin
          state_d = SHOW;
          idx_d   = '0;
          snap_d  = inputs_snap;
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) state_d = BLANK;
      end
      BLANK: begin
        if (cnt_q == SLOT_LAST) begin
          cnt_d   = '0;
          state_d = SHOW;
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) snap_d = inputs_snap;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!en) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end
  end

  // A digit is a leading zero when it and every higher nibble are zero.
  always_comb begin
    lead_zero[3] = (snap_d.digits[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] && (snap_d.digits[11:8] == 4'd0);
    lead_zero[1] = lead_zero[2] && (snap_d.digits[7:4] == 4'd0);
    lead_zero[0] = 1'b0;
  end

  assign nibble = snap_d.digits[{idx_d, 2'b00} +: 4];

  seg7_decoder u_decoder (
    .nibble (nibble),
    .seg    (glyph)
  );

  // Outputs are computed from next-state values so they change on the same edge.
  always_comb begin
    lit          = (state_d == SHOW) && !(snap_d.blank_lz && lead_zero[idx_d]);
    an_d         = (lit ? (4'b0001 << idx_d) : 4'b0000) ^ AN_POL;
    seg_d        = (lit ? glyph : SEG_OFF) ^ SEG_POL;
    dp_d         = (lit && snap_d.dp[idx_d]) ^ ACTIVE_LOW;
    frame_done_d = (state_d == BLANK) && (cnt_d == SLOT_LAST) && (idx_d == 2'd3);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      snap_q       <= '0;
      an_q         <= AN_POL;
      seg_q        <= SEG_POL;
      dp_q         <= ACTIVE_LOW;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      snap_q       <= snap_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule
